// File: rtl/xt_feed_ctl.sv
// rtl/xt_feed_ctl.sv - instruction queue feeding stg_xt with per-instruction uop expansion
`ifndef HBIT_ADDR
`define HBIT_ADDR 15
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 31
`endif
`ifndef OPC_NOP
`define OPC_NOP 16'h0013
`endif

module xt_feed_ctl #(
    parameter int DEPTH = 2
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_flush,
    input  logic                 iw_if_valid,
    input  logic [`HBIT_ADDR:0]  iw_if_pc,
    input  logic [`HBIT_DATA:0]  iw_if_instr,
    input  logic [2:0]           iw_if_len,
    output logic                 ow_if_ready,
    input  logic                 iw_xt_stall,
    output logic                 ow_xt_valid,
    output logic [`HBIT_ADDR:0]  ow_xt_pc,
    output logic [`HBIT_DATA:0]  ow_xt_instr,
    output logic [1:0]           ow_xt_idx,
    output logic                 ow_xt_last,
    output logic                 ow_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         head_q, head_d;
    logic [AW-1:0]         tail_q, tail_d;
    logic [1:0]            idx_q, idx_d;
    logic [`HBIT_ADDR:0]   pc_q [DEPTH];
    logic [`HBIT_ADDR:0]   pc_d [DEPTH];
    logic [`HBIT_DATA:0]   instr_q [DEPTH];
    logic [`HBIT_DATA:0]   instr_d [DEPTH];
    // Lengths are kept as (len-1) so a 2-bit field covers 1..4 uops.
    logic [1:0]            lenm1_q [DEPTH];
    logic [1:0]            lenm1_d [DEPTH];

    logic [1:0]            if_lenm1;
    logic                  push;
    logic                  pop;
    logic                  at_last;

    always_comb begin
        case (iw_if_len)
            3'd0, 3'd1: if_lenm1 = 2'd0;
            3'd2:       if_lenm1 = 2'd1;
            3'd3:       if_lenm1 = 2'd2;
            default:    if_lenm1 = 2'd3;
        endcase
    end

    assign ow_if_ready = (count_q < CW'(DEPTH)) && !iw_rst && !iw_flush;
    assign push        = iw_if_valid && ow_if_ready;
    assign at_last     = (state_q == ST_EMIT) && (idx_q == lenm1_q[head_q]);
    assign pop         = at_last && !iw_xt_stall;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        idx_d   = idx_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        lenm1_d = lenm1_q;

        if (iw_flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            idx_d   = '0;
        end else begin
            if (push) begin
                pc_d[tail_q]    = iw_if_pc;
                instr_d[tail_q] = iw_if_instr;
                lenm1_d[tail_q] = if_lenm1;
                tail_d          = tail_q + AW'(1);
            end
            if ((state_q == ST_EMIT) && !iw_xt_stall) begin
                if (at_last) begin
                    head_d = head_q + AW'(1);
                    idx_d  = 2'd0;
                end else begin
                    idx_d  = idx_q + 2'd1;
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        state_d = (count_d != '0) ? ST_EMIT : ST_IDLE;
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            idx_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                lenm1_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            lenm1_q <= lenm1_d;
        end
    end

    assign ow_xt_valid = (count_q != '0);
    assign ow_busy     = ow_xt_valid;
    assign ow_xt_pc    = ow_xt_valid ? pc_q[head_q] : '0;
    assign ow_xt_instr = ow_xt_valid ? instr_q[head_q] : {`OPC_NOP, 16'b0};
    assign ow_xt_idx   = ow_xt_valid ? idx_q : 2'd0;
    assign ow_xt_last  = ow_xt_valid && (idx_q == lenm1_q[head_q]);

endmodule

// File: doc/xt_feed_ctl.md
XT_FEED_CTL -- requirements
Module: xt_feed_ctl

Interface
REQ-001 SHALL use the single clock iw_clk; reset iw_rst is synchronous and active-high.
REQ-002 SHALL have parameter DEPTH, default 2, giving the number of instruction queue entries (power of two, 2 or 4).
REQ-003 Ports (name  direction  width  meaning):
- iw_clk  in  1  clock
- iw_rst  in  1  sync active-high reset
- iw_flush  in  1  pipeline flush, drops all queued and in-flight work
- iw_if_valid  in  1  fetch presents an instruction
- iw_if_pc  in  `HBIT_ADDR+1  fetch PC
- iw_if_instr  in  `HBIT_DATA+1  fetched macro instruction
- iw_if_len  in  3  µop count for that instruction, 1..4; 0 is treated as 1, 5..7 are treated as 4
- ow_if_ready  out  1  queue accepts an instruction this cycle
- iw_xt_stall  in  1  stg_xt or a downstream stage holds the current µop
- ow_xt_valid  out  1  ow_xt_* carries a live µop slot
- ow_xt_pc  out  `HBIT_ADDR+1  PC of the head instruction
- ow_xt_instr  out  `HBIT_DATA+1  head instruction, or {`OPC_NOP,16'b0} when invalid
- ow_xt_idx  out  2  µop index within the head expansion
- ow_xt_last  out  1  current index is the final µop of the head
- ow_busy  out  1  queue non-empty

Function
REQ-004 SHALL hold a DEPTH-entry FIFO of {pc, instr, len}, with a count register of width clog2(DEPTH)+1 and head/tail pointers that wrap modulo DEPTH.
REQ-005 ow_if_ready SHALL be 1 when count<DEPTH and iw_rst=0 and iw_flush=0, and 0 otherwise. It is combinational from registered state.
REQ-006 Push SHALL occur on a rising edge when iw_if_valid && ow_if_ready; an entry is written at tail and tail advances.
REQ-007 ow_xt_* SHALL be driven from the head entry and the idx register. An instruction pushed into an empty queue at edge N SHALL appear on ow_xt_* after edge N (1-cycle latency).
REQ-008 ow_xt_valid SHALL equal (count!=0). When the queue is empty: ow_xt_instr={`OPC_NOP,16'b0}, ow_xt_pc=0, ow_xt_idx=0, ow_xt_last=0.
REQ-009 Sequencer states SHALL be IDLE (count=0) and EMIT (count>0); idx SHALL be meaningful only in EMIT.
REQ-010 In EMIT, on each edge with iw_xt_stall=0: if idx < len_head-1, idx increments. Otherwise (ow_xt_last=1) the head pops, head advances, and idx resets to 0.
REQ-011 iw_xt_stall=1 SHALL freeze idx, head and all ow_xt_* outputs; pushes still proceed while not full.
REQ-012 ow_xt_last SHALL be 1 when ow_xt_valid && idx==len_head-1, using the normalized length (REQ-003).
REQ-013 Push and pop on the same edge SHALL leave count unchanged and update both pointers. When full, ow_if_ready=0 even if a pop occurs that edge (no fall-through).
REQ-014 A single-µop instruction SHALL pop after one unstalled cycle, giving back-to-back throughput of one instruction per cycle.
REQ-015 iw_flush=1 at an edge SHALL clear count, head, tail and idx, and SHALL suppress any push that edge. Flush has priority over push, pop and stall. Outputs show the empty values after the edge.
REQ-016 The normalized length SHALL be stored at push; iw_if_len is never re-sampled for a queued entry.
REQ-017 ow_busy SHALL equal (count!=0).

Reset
REQ-018 On iw_rst=1 at an edge: count=0, head=0, tail=0, idx=0, and FIFO storage cleared to zero. After the edge, outputs show the REQ-008 empty values and ow_busy=0.
REQ-019 While iw_rst=1, ow_if_ready=0 and no push occurs. Reset mid-expansion SHALL abandon the expansion with no further µops.
REQ-020 Reset SHALL take priority over flush, push, pop and stall.

Verification
REQ-021 Bench SHALL cover at least these scenarios:
- Reset, then idle -> ow_xt_valid=0, ow_xt_instr={`OPC_NOP,16'b0}, ow_if_ready=1, ow_busy=0.
- Push a len=4 instruction at pc=0x10, no stall -> idx 0,1,2,3 on 4 consecutive cycles; last=1 only at idx=3; then empty.
- Three len=1 instructions back-to-back -> one per cycle on ow_xt_instr with last=1 each; ow_if_ready never drops.
- len=3 head with stall asserted at idx=1 for 3 cycles while fetch pushes 2 more (DEPTH=2) -> idx holds at 1; ow_if_ready=0 once count=2; order preserved afterwards.
- Flush at idx=2 of a len=4 expansion with a simultaneous iw_if_valid -> next cycle count=0 and ow_xt_valid=0; the concurrent instruction is not queued.
- iw_if_len=0 and iw_if_len=7 -> treated as 1 and 4 µops respectively; synchronous reset asserted mid-expansion -> empty on the next cycle.
